// File: rtl/phy_link_supervisor_pkg.sv
// rtl/phy_link_supervisor_pkg.sv - state encodings, default timing constants and backoff helper
// Shared by phy_link_supervisor and phy_tx_mux. Defining SUPERVISOR_STATS_EN at build time
// adds the linkup_events / link_drops / last_attempt_cycles statistics ports to the top.
package phy_link_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED   = 3'd0,
        ST_HOLD_RESET = 3'd1,
        ST_WAIT_LINK  = 3'd2,
        ST_BACKOFF    = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_ACTIVE     = 3'd5,
        ST_FAILED     = 3'd6
    } sup_state_e;

    localparam int unsigned DEF_RESET_HOLD        = 16;
    localparam int unsigned DEF_LINKUP_TIMEOUT    = 32'd1000000;
    localparam int unsigned DEF_SETTLE            = 32;
    localparam int unsigned DEF_BACKOFF_BASE      = 256;
    localparam int unsigned DEF_BACKOFF_SHIFT_MAX = 6;
    localparam int unsigned DEF_MAX_RETRIES       = 8;

    // Timer load for the backoff after failure number n (n >= 1): the backoff
    // doubles per failure until the shift cap, then stays flat.
    function automatic logic [31:0] backoff_load(input logic [31:0] base,
                                                 input logic [3:0]  shift_max,
                                                 input logic [3:0]  n);
        logic [3:0] sh;
        sh = n - 4'd1;
        if (sh > shift_max) begin
            sh = shift_max;
        end
        return (base << sh) - 32'd1;
    endfunction

endpackage

// File: rtl/phy_tx_mux.sv
// rtl/phy_tx_mux.sv - registered transmit selector between OOB controller and link layer
// Ports: clk, rst (sync, active-high); flush_i loads idle values; sel_ll_i picks the link
// layer; force_idle_i forces electrical idle on the OOB path; oob_* / ll_* are the two
// sources; tx_dout_o / tx_is_k_o / tx_elec_idle_o are the registered transceiver outputs.
module phy_tx_mux
    import phy_link_supervisor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        sel_ll_i,
    input  logic        force_idle_i,
    input  logic [31:0] oob_dout_i,
    input  logic        oob_is_k_i,
    input  logic        oob_elec_idle_i,
    input  logic [31:0] ll_dout_i,
    input  logic        ll_is_k_i,
    output logic [31:0] tx_dout_o,
    output logic        tx_is_k_o,
    output logic        tx_elec_idle_o
);

    logic [31:0] tx_dout_q;
    logic        tx_is_k_q;
    logic        tx_elec_idle_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            tx_dout_q      <= '0;
            tx_is_k_q      <= 1'b0;
            tx_elec_idle_q <= 1'b1;
        end else if (sel_ll_i) begin
            tx_dout_q      <= ll_dout_i;
            tx_is_k_q      <= ll_is_k_i;
            tx_elec_idle_q <= 1'b0;
        end else begin
            tx_dout_q      <= oob_dout_i;
            tx_is_k_q      <= oob_is_k_i;
            // A held-in-reset OOB controller must never wake the line.
            tx_elec_idle_q <= force_idle_i | oob_elec_idle_i;
        end
    end

    assign tx_dout_o      = tx_dout_q;
    assign tx_is_k_o      = tx_is_k_q;
    assign tx_elec_idle_o = tx_elec_idle_q;

endmodule

// File: rtl/phy_link_supervisor.sv
// rtl/phy_link_supervisor.sv - SATA PHY link-up supervisor with timed retries and exponential backoff
// Ports: clk, rst (sync, active-high), enable, restart, oob_linkup, oob_platform_error in;
// oob_rst out; OOB and link-layer transmit sources in; tx_dout / tx_is_k / tx_set_elec_idle
// out to the transceiver; phy_ready, link_failed, retry_count, sup_state status out.
// Build with SUPERVISOR_STATS_EN defined to add linkup_events, link_drops, last_attempt_cycles.
module phy_link_supervisor
    import phy_link_supervisor_pkg::*;
#(
    parameter int unsigned RESET_HOLD        = DEF_RESET_HOLD,
    parameter int unsigned LINKUP_TIMEOUT    = DEF_LINKUP_TIMEOUT,
    parameter int unsigned SETTLE            = DEF_SETTLE,
    parameter int unsigned BACKOFF_BASE      = DEF_BACKOFF_BASE,
    parameter int unsigned BACKOFF_SHIFT_MAX = DEF_BACKOFF_SHIFT_MAX,
    parameter int unsigned MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        restart,
    input  logic        oob_linkup,
    input  logic        oob_platform_error,
    output logic        oob_rst,
    input  logic [31:0] oob_tx_dout,
    input  logic        oob_tx_is_k,
    input  logic        oob_tx_elec_idle,
    input  logic [31:0] ll_tx_dout,
    input  logic        ll_tx_is_k,
    output logic [31:0] tx_dout,
    output logic        tx_is_k,
    output logic        tx_set_elec_idle,
    output logic        phy_ready,
    output logic        link_failed,
    output logic [3:0]  retry_count,
    output logic [2:0]  sup_state
`ifdef SUPERVISOR_STATS_EN
    ,
    output logic [15:0] linkup_events,
    output logic [15:0] link_drops,
    output logic [31:0] last_attempt_cycles
`endif
);

    sup_state_e  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic        fail;
    logic        link_lost;
    logic [3:0]  new_retry;

    assign link_lost = !oob_linkup || oob_platform_error;
    assign new_retry = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
        retry_d = retry_q;
        fail    = 1'b0;

        case (state_q)
            ST_DISABLED: begin
                if (enable) begin
                    state_d = ST_HOLD_RESET;
                    timer_d = 32'(RESET_HOLD - 1);
                    retry_d = 4'd0;
                end
            end
            ST_HOLD_RESET: begin
                if (timer_q == 32'd0) begin
                    state_d = ST_WAIT_LINK;
                    timer_d = 32'(LINKUP_TIMEOUT - 1);
                end
            end
            ST_WAIT_LINK: begin
                if (oob_linkup) begin
                    state_d = ST_SETTLE;
                    timer_d = 32'(SETTLE - 1);
                end else if (timer_q == 32'd0) begin
                    fail = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (link_lost) begin
                    fail = 1'b1;
                end else if (timer_q == 32'd0) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // A drop after link-up starts a fresh sequence, not a counted failure.
                if (link_lost) begin
                    state_d = ST_HOLD_RESET;
                    timer_d = 32'(RESET_HOLD - 1);
                    retry_d = 4'd0;
                end
            end
            ST_BACKOFF: begin
                if (timer_q == 32'd0) begin
                    state_d = ST_HOLD_RESET;
                    timer_d = 32'(RESET_HOLD - 1);
                end
            end
            ST_FAILED: begin
            end
            default: begin
                state_d = ST_DISABLED;
                timer_d = 32'd0;
            end
        endcase

        if (fail) begin
            retry_d = new_retry;
            if (new_retry == 4'(MAX_RETRIES)) begin
                state_d = ST_FAILED;
                timer_d = 32'd0;
            end else begin
                state_d = ST_BACKOFF;
                timer_d = backoff_load(32'(BACKOFF_BASE), 4'(BACKOFF_SHIFT_MAX), new_retry);
            end
        end

        // restart outranks failure/expiry; enable low outranks restart.
        if (restart && state_q != ST_DISABLED) begin
            state_d = ST_HOLD_RESET;
            timer_d = 32'(RESET_HOLD - 1);
            retry_d = 4'd0;
        end
        if (!enable) begin
            state_d = ST_DISABLED;
            timer_d = 32'd0;
            retry_d = retry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DISABLED;
            timer_q <= 32'd0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    // Status flags are pure decodes of the registered state, so they change in
    // the same update that moves the state.
    assign oob_rst     = !(state_q == ST_WAIT_LINK || state_q == ST_SETTLE || state_q == ST_ACTIVE);
    assign phy_ready   = (state_q == ST_ACTIVE);
    assign link_failed = (state_q == ST_FAILED);
    assign retry_count = retry_q;
    assign sup_state   = state_q;

    phy_tx_mux u_tx_mux (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (!enable),
        .sel_ll_i        (phy_ready),
        .force_idle_i    (oob_rst),
        .oob_dout_i      (oob_tx_dout),
        .oob_is_k_i      (oob_tx_is_k),
        .oob_elec_idle_i (oob_tx_elec_idle),
        .ll_dout_i       (ll_tx_dout),
        .ll_is_k_i       (ll_tx_is_k),
        .tx_dout_o       (tx_dout),
        .tx_is_k_o       (tx_is_k),
        .tx_elec_idle_o  (tx_set_elec_idle)
    );

`ifdef SUPERVISOR_STATS_EN
    logic [15:0] up_q;
    logic [15:0] drop_q;
    logic [31:0] att_q;
    logic [31:0] last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q   <= '0;
            drop_q <= '0;
            att_q  <= '0;
            last_q <= '0;
        end else begin
            if (state_q == ST_SETTLE && state_d == ST_ACTIVE) begin
                if (up_q != 16'hFFFF) up_q <= up_q + 16'd1;
                last_q <= att_q;
            end
            if (state_q == ST_ACTIVE && state_d == ST_HOLD_RESET && link_lost) begin
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
            // Counts cycles spent in WAIT_LINK for the current attempt.
            if (state_q != ST_WAIT_LINK && state_d == ST_WAIT_LINK) begin
                att_q <= '0;
            end else if (state_q == ST_WAIT_LINK && att_q != 32'hFFFF_FFFF) begin
                att_q <= att_q + 32'd1;
            end
        end
    end

    assign linkup_events       = up_q;
    assign link_drops          = drop_q;
    assign last_attempt_cycles = last_q;
`endif

endmodule

// File: doc/phy_link_supervisor.md
Name: phy_link_supervisor

Overview:
Supervises the SATA PHY out-of-band controller. It holds the OOB controller in reset, times each link-up attempt, and retries with exponential backoff. It declares the PHY ready to the link layer and arbitrates the shared transmit datapath: OOB controller before link-up, link layer after. It sits between the platform/transceiver wrapper, the OOB controller and the link layer.

Parameters:
RESET_HOLD, 16, cycles oob_rst is held high at the start of each attempt (min 1)
LINKUP_TIMEOUT, 32'd1000000, cycles allowed from oob_rst release to oob_linkup
SETTLE, 32, cycles oob_linkup must stay high before phy_ready
BACKOFF_BASE, 256, base backoff cycles after a failed attempt
BACKOFF_SHIFT_MAX, 6, cap on the backoff left-shift
MAX_RETRIES, 8, failed attempts before entering FAILED (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  level; low forces DISABLED
restart  in  1  strobe; begin a fresh attempt sequence
oob_linkup  in  1  linkup from the OOB controller
oob_platform_error  in  1  platform_error from the OOB controller
oob_rst  out  1  reset to the OOB controller
oob_tx_dout  in  32  OOB controller transmit data
oob_tx_is_k  in  1  OOB controller K flag
oob_tx_elec_idle  in  1  OOB controller electrical-idle request
ll_tx_dout  in  32  link layer transmit data
ll_tx_is_k  in  1  link layer K flag
tx_dout  out  32  to transceiver
tx_is_k  out  1  to transceiver
tx_set_elec_idle  out  1  to transceiver
phy_ready  out  1  link usable by the link layer
link_failed  out  1  retries exhausted
retry_count  out  4  failed attempts in the current sequence
sup_state  out  3  current state, for debug

Behaviour:
- Reset values: oob_rst=1, phy_ready=0, link_failed=0, retry_count=0, sup_state=DISABLED, tx_dout=0, tx_is_k=0, tx_set_elec_idle=1, timer=0, and the datapath select points at the OOB controller.
- State encoding: DISABLED=0, HOLD_RESET=1, WAIT_LINK=2, BACKOFF=3, SETTLE=4, ACTIVE=5, FAILED=6. Any other value goes to DISABLED.
- One 32-bit down-counter timer. It decrements while non-zero. "Expired" means timer==0.
- Transitions:
  - DISABLED: oob_rst=1. When enable=1, go to HOLD_RESET with timer=RESET_HOLD-1 and retry_count=0.
  - HOLD_RESET: oob_rst=1. On expiry, go to WAIT_LINK with timer=LINKUP_TIMEOUT-1.
  - WAIT_LINK: oob_rst=0.
    - oob_linkup=1: go to SETTLE with timer=SETTLE-1.
    - Expired without linkup: this is a failure.
  - SETTLE: oob_rst=0.
    - oob_linkup=0 or oob_platform_error=1: this is a failure.
    - Expired: go to ACTIVE, set phy_ready=1 and switch the datapath select to the link layer.
  - ACTIVE:
    - oob_linkup=0 or oob_platform_error=1: phy_ready=0 in the same registered update; select back to OOB; retry_count=0; go to HOLD_RESET with timer=RESET_HOLD-1.
  - Failure handling: retry_count+1.
    - If the new count equals MAX_RETRIES: go to FAILED, link_failed=1, oob_rst=1.
    - Otherwise: go to BACKOFF with timer = (BACKOFF_BASE << min(newcount-1, BACKOFF_SHIFT_MAX)) - 1, oob_rst=1.
  - BACKOFF: oob_rst=1. On expiry, go to HOLD_RESET with timer=RESET_HOLD-1.
  - FAILED: holds until restart or enable=0.
- restart=1 in any state except DISABLED: go to HOLD_RESET, retry_count=0, link_failed=0, phy_ready=0, select to OOB. restart takes priority over any same-cycle failure or expiry.
- enable=0 overrides everything, including restart: next cycle is DISABLED with outputs at their reset values except retry_count, which holds.
- Datapath: tx_dout, tx_is_k and tx_set_elec_idle are registered, one-cycle latency from the selected source.
  - Link-layer selection drives tx_set_elec_idle=0.
  - The OOB path passes oob_tx_elec_idle, forced to 1 whenever oob_rst=1.
- retry_count saturates at 15 and never wraps.

Optional Feature:
SUPERVISOR_STATS_EN. When defined, three additional output ports exist:
- linkup_events (16-bit): count of SETTLE->ACTIVE transitions.
- link_drops (16-bit): count of ACTIVE->HOLD_RESET transitions caused by linkup loss or platform error.
- last_attempt_cycles (32-bit): WAIT_LINK entry to linkup, latched on SETTLE->ACTIVE.

All three counters saturate, reset to 0 on rst only, and are unaffected by restart or enable. When the macro is undefined, these ports and their logic are absent.

Decomposition:
- Shared package/defines file (beside sata_defines.v): state encodings, default timing constants, and the SUPERVISOR_STATS_EN guard.
- One natural sub-module, phy_tx_mux: the registered transmit selector with the elec-idle forcing rule.

Test Plan:
- Nominal bring-up (RESET_HOLD=4, SETTLE=8): enable=1; oob_linkup rises 20 cycles after oob_rst falls -> phy_ready=1 exactly 8 cycles after linkup; tx_dout follows ll_tx_dout with 1-cycle latency; tx_set_elec_idle=0.
- Backoff growth (BACKOFF_BASE=4, SHIFT_MAX=2, LINKUP_TIMEOUT=10): oob_linkup never rises -> successive BACKOFF lengths 4, 8, 16, 16 cycles; retry_count increments 1,2,3,4.
- Exhaustion (MAX_RETRIES=3): no linkup -> FAILED after the 3rd timeout, link_failed=1, oob_rst=1; restart pulse -> link_failed=0, retry_count=0, state HOLD_RESET.
- Link loss in ACTIVE: drop oob_linkup for 1 cycle -> phy_ready=0 on the next edge, tx source returns to OOB, retry_count=0; with SUPERVISOR_STATS_EN, link_drops=1.
- Glitch in SETTLE: oob_linkup low at SETTLE cycle 5 -> BACKOFF, retry_count=1, phy_ready never asserted.
- Precedence: restart and a WAIT_LINK timeout in the same cycle -> HOLD_RESET with retry_count=0; enable=0 with restart in the same cycle -> DISABLED.
